thread_scheduler: RTL and testbench

//  Barrel-style issue controller for one Arya core: owns per-thread PCs and issues one fetch per cycle
//  to the shared fetch/decode/ALU datapath. Threads are picked round-robin.
//  A thread has at most one instruction in flight. Decode/execute reports branch, halt and offset for

---
 rtl/thread_scheduler_pkg.sv | 12 +
 rtl/thread_scheduler_rr_arbiter.sv | 30 +++
 rtl/thread_scheduler.sv | 98 +++++++++
 tb/tb_thread_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
// thread_scheduler_pkg: shared parameters, thread state encoding and opcode constants
package thread_scheduler_pkg;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_TID_WIDTH = 2;
  localparam int DEF_INST_ADDR_WIDTH = 9;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WAIT  = 2'd2
  } thread_state_t;
endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// thread_scheduler_rr_arbiter: combinational round-robin pick starting after the last grant
module thread_scheduler_rr_arbiter
  import thread_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int TID_WIDTH = DEF_TID_WIDTH
) (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [TID_WIDTH-1:0]   last,
  output logic [NUM_THREADS-1:0] gnt,
  output logic [TID_WIDTH-1:0]   gnt_tid,
  output logic                   gnt_valid
);
  // scan last+1 .. last+NUM_THREADS; the index wraps naturally since NUM_THREADS is a power of 2
  always_comb begin
    logic [TID_WIDTH-1:0] idx;
    idx = '0;
    gnt = '0;
    gnt_tid = '0;
    gnt_valid = 1'b0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      idx = last + TID_WIDTH'(k);
      if (!gnt_valid && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_tid = idx;
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/thread_scheduler.sv
// thread_scheduler: barrel-style round-robin issue controller owning per-thread PCs
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int TID_WIDTH = DEF_TID_WIDTH,
  parameter int INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_valid,
  input  logic [TID_WIDTH-1:0]       start_tid,
  input  logic [INST_ADDR_WIDTH-1:0] start_pc,
  output logic                       start_ready,
  input  logic                       stall_in,
  output logic                       issue_valid,
  output logic [TID_WIDTH-1:0]       issue_tid,
  output logic [INST_ADDR_WIDTH-1:0] issue_pc,
  input  logic                       resolve_valid,
  input  logic [TID_WIDTH-1:0]       resolve_tid,
  input  logic                       resolve_taken,
  input  logic [INST_ADDR_WIDTH-1:0] resolve_offset,
  input  logic                       resolve_halt,
  output logic [NUM_THREADS-1:0]     thread_active,
  output logic                       all_halted,
  output logic                       protocol_err
);
  thread_state_t              st   [NUM_THREADS];
  thread_state_t              st_n [NUM_THREADS];
  logic [INST_ADDR_WIDTH-1:0] pc   [NUM_THREADS];
  logic [INST_ADDR_WIDTH-1:0] pc_n [NUM_THREADS];
  logic [TID_WIDTH-1:0]       rr;
  logic [NUM_THREADS-1:0]     req;
  logic [NUM_THREADS-1:0]     gnt;
  logic [TID_WIDTH-1:0]       gnt_tid;
  logic                       gnt_valid;
  logic                       resolve_ok;

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
    assign req[i] = (st[i] == ST_READY) && !stall_in;
    assign thread_active[i] = st[i] != ST_IDLE;
  end

  assign all_halted = ~|thread_active;
  assign start_ready = st[start_tid] == ST_IDLE;
  assign resolve_ok = st[resolve_tid] == ST_WAIT;

  thread_scheduler_rr_arbiter #(
    .NUM_THREADS(NUM_THREADS),
    .TID_WIDTH(TID_WIDTH)
  ) u_arb (
    .req(req),
    .last(rr),
    .gnt(gnt),
    .gnt_tid(gnt_tid),
    .gnt_valid(gnt_valid)
  );

  // start, resolve and issue touch IDLE, WAIT and READY threads respectively, so they never collide
  always_comb begin
    st_n = st;
    pc_n = pc;
    if (start_valid && start_ready) begin
      st_n[start_tid] = ST_READY;
      pc_n[start_tid] = start_pc;
    end
    if (resolve_valid && resolve_ok) begin
      st_n[resolve_tid] = resolve_halt ? ST_IDLE : ST_READY;
      pc_n[resolve_tid] = resolve_halt  ? pc[resolve_tid] :
                          resolve_taken ? pc[resolve_tid] + resolve_offset :
                                          pc[resolve_tid] + 1'b1;
    end
    for (int i = 0; i < NUM_THREADS; i++) st_n[i] = gnt[i] ? ST_WAIT : st_n[i];
  end

  // thread state, PCs, round-robin pointer and issue/error output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        st[i] <= ST_IDLE;
        pc[i] <= '0;
      end
      rr <= TID_WIDTH'(NUM_THREADS - 1);
      issue_valid <= 1'b0;
      issue_tid <= '0;
      issue_pc <= '0;
      protocol_err <= 1'b0;
    end else begin
      st <= st_n;
      pc <= pc_n;
      rr <= gnt_valid ? gnt_tid : rr;
      issue_valid <= gnt_valid;
      issue_tid <= gnt_tid;
      issue_pc <= pc[gnt_tid];
      protocol_err <= resolve_valid && !resolve_ok;
    end
  end
endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed scenarios plus random traffic against a thread-level reference model
module tb_thread_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic [1:0] start_tid = '0;
  logic [8:0] start_pc = '0;
  logic       start_ready;
  logic       stall_in = 1'b0;
  logic       issue_valid;
  logic [1:0] issue_tid;
  logic [8:0] issue_pc;
  logic       resolve_valid = 1'b0;
  logic [1:0] resolve_tid = '0;
  logic       resolve_taken = 1'b0;
  logic [8:0] resolve_offset = '0;
  logic       resolve_halt = 1'b0;
  logic [3:0] thread_active;
  logic       all_halted;
  logic       protocol_err;

  int checks = 0;
  int errors = 0;

  // reference model: which threads run, which have an instruction out, their PCs, last issued
  bit m_busy [4];
  bit m_fly  [4];
  int m_pc   [4];
  int m_last;
  bit e_iv;
  int e_tid;
  int e_pc;
  bit e_err;

  thread_scheduler dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_tid(start_tid), .start_pc(start_pc), .start_ready(start_ready),
    .stall_in(stall_in),
    .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
    .resolve_valid(resolve_valid), .resolve_tid(resolve_tid), .resolve_taken(resolve_taken),
    .resolve_offset(resolve_offset), .resolve_halt(resolve_halt),
    .thread_active(thread_active), .all_halted(all_halted), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [3:0] m_active();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0;
      m_fly[i] = 0;
      m_pc[i] = 0;
    end
    m_last = 3;
    e_iv = 0;
    e_tid = 0;
    e_pc = 0;
    e_err = 0;
  endtask

  // advance model by the current inputs, then clock the DUT and settle past the edge
  task automatic tick();
    int pick;
    int off;
    if (reset) model_reset();
    else begin
      e_err = resolve_valid && !m_fly[resolve_tid];
      pick = -1;
      if (!stall_in)
        for (int k = 1; k <= 4; k++)
          if (pick < 0 && m_busy[(m_last + k) % 4] && !m_fly[(m_last + k) % 4]) pick = (m_last + k) % 4;
      if (start_valid && !m_busy[start_tid]) begin
        m_busy[start_tid] = 1;
        m_fly[start_tid] = 0;
        m_pc[start_tid] = int'(start_pc);
      end
      if (resolve_valid && m_fly[resolve_tid]) begin
        m_fly[resolve_tid] = 0;
        if (resolve_halt) m_busy[resolve_tid] = 0;
        else begin
          off = !resolve_taken ? 1 : (resolve_offset >= 9'd256 ? int'(resolve_offset) - 512 : int'(resolve_offset));
          m_pc[resolve_tid] = (m_pc[resolve_tid] + off + 512) % 512;
        end
      end
      e_iv = pick >= 0;
      if (e_iv) begin
        e_tid = pick;
        e_pc = m_pc[pick];
        m_fly[pick] = 1;
        m_last = pick;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_valid = 0;
    stall_in = 0;
    resolve_valid = 0;
    resolve_taken = 0;
    resolve_halt = 0;
    resolve_offset = '0;
  endtask

  task automatic apply_reset(input int n);
    idle_inputs();
    reset = 1;
    repeat (n) tick();
    reset = 0;
  endtask

  task automatic do_start(input logic [1:0] t, input logic [8:0] p);
    start_valid = 1;
    start_tid = t;
    start_pc = p;
    tick();
    start_valid = 0;
  endtask

  task automatic do_resolve(input logic [1:0] t, input logic tk, input logic [8:0] off, input logic hl);
    resolve_valid = 1;
    resolve_tid = t;
    resolve_taken = tk;
    resolve_offset = off;
    resolve_halt = hl;
    tick();
    resolve_valid = 0;
    resolve_taken = 0;
    resolve_halt = 0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      if (issue_valid === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++;
    if (issue_valid !== 1'b0 || thread_active !== 4'b0000 || all_halted !== 1'b1 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: iv=%b active=%b halted=%b perr=%b, need 0 0000 1 0",
               issue_valid, thread_active, all_halted, protocol_err);
    end
    for (int t = 0; t < 4; t++) begin
      start_tid = 2'(t);
      #1;
      checks++;
      if (start_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_start_ready tid%0d: got %b, need 1", t, start_ready);
      end
    end
  endtask

  task automatic test_single_thread();
    bit ok;
    apply_reset(1);
    do_start(2'd0, 9'h010);
    for (int k = 0; k < 3; k++) begin
      wait_issue(ok);
      checks++;
      if (!ok || issue_tid !== 2'd0 || issue_pc !== 9'h010 + 9'(k) || issue_pc !== 9'(e_pc)) begin
        errors++;
        $display("FAIL single_issue%0d: ok=%0d tid=%0d pc=%h, need tid 0 pc %h", k, ok, issue_tid, issue_pc, 9'h010 + 9'(k));
      end
      checks++;
      if (thread_active !== 4'b0001 || all_halted !== 1'b0) begin
        errors++;
        $display("FAIL single_active%0d: active=%b halted=%b, need 0001 0", k, thread_active, all_halted);
      end
      do_resolve(2'd0, 1'b0, 9'd0, k == 2);
    end
    checks++;
    if (thread_active !== 4'b0000 || all_halted !== 1'b1) begin
      errors++;
      $display("FAIL single_halt: active=%b halted=%b, need 0000 1", thread_active, all_halted);
    end
  endtask

  task automatic test_round_robin();
    apply_reset(1);
    for (int c = 0; c < 16; c++) begin
      start_valid = c < 4;
      start_tid = 2'(c);
      start_pc = 9'(c * 32);
      tick();
      resolve_valid = 0;
      if (c >= 1) begin
        checks++;
        if (issue_valid !== 1'b1 || issue_tid !== 2'((c - 1) % 4) || issue_pc !== 9'(e_pc) || !e_iv) begin
          errors++;
          $display("FAIL rr_cycle%0d: iv=%b tid=%0d pc=%h, need 1 %0d %h", c, issue_valid, issue_tid, issue_pc, (c - 1) % 4, e_pc);
        end
      end
      resolve_valid = issue_valid;
      resolve_tid = issue_tid;
    end
    idle_inputs();
  endtask

  task automatic test_branch_wrap();
    bit ok;
    logic [8:0] pcs [4];
    logic [8:0] offs [3];
    logic       tks [3];
    pcs = '{9'h1FE, 9'h003, 9'h1FF, 9'h000};
    offs = '{9'h005, 9'h1FC, 9'h000};
    tks = '{1'b1, 1'b1, 1'b0};
    apply_reset(1);
    do_start(2'd2, 9'h1FE);
    for (int k = 0; k < 4; k++) begin
      wait_issue(ok);
      checks++;
      if (!ok || issue_tid !== 2'd2 || issue_pc !== pcs[k]) begin
        errors++;
        $display("FAIL branch_pc%0d: ok=%0d tid=%0d pc=%h, need tid 2 pc %h", k, ok, issue_tid, issue_pc, pcs[k]);
      end
      if (k < 3) do_resolve(2'd2, tks[k], offs[k], 1'b0);
    end
  endtask

  task automatic test_stall_collision();
    apply_reset(1);
    stall_in = 1;
    do_start(2'd1, 9'h0A0);
    do_start(2'd3, 9'h120);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: issue_valid=%b, need 0", k, issue_valid);
      end
    end
    stall_in = 0;
    tick();
    checks++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd1 || issue_pc !== 9'h0A0) begin
      errors++;
      $display("FAIL stall_release: iv=%b tid=%0d pc=%h, need 1 1 0a0", issue_valid, issue_tid, issue_pc);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd3 || issue_pc !== 9'h120) begin
      errors++;
      $display("FAIL stall_second: iv=%b tid=%0d pc=%h, need 1 3 120", issue_valid, issue_tid, issue_pc);
    end
    start_valid = 1;
    start_tid = 2'd0;
    start_pc = 9'h040;
    do_resolve(2'd3, 1'b0, 9'd0, 1'b0);
    start_valid = 0;
    checks++;
    if (issue_valid !== 1'b0 || thread_active !== 4'b1011) begin
      errors++;
      $display("FAIL collision_state: iv=%b active=%b, need 0 1011", issue_valid, thread_active);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd0 || issue_pc !== 9'h040) begin
      errors++;
      $display("FAIL collision_start_issue: iv=%b tid=%0d pc=%h, need 1 0 040", issue_valid, issue_tid, issue_pc);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd3 || issue_pc !== 9'h121) begin
      errors++;
      $display("FAIL collision_resolve_issue: iv=%b tid=%0d pc=%h, need 1 3 121", issue_valid, issue_tid, issue_pc);
    end
  endtask

  task automatic test_errors_reset();
    bit ok;
    apply_reset(1);
    do_resolve(2'd2, 1'b1, 9'h004, 1'b0);
    checks++;
    if (protocol_err !== 1'b1 || thread_active !== 4'b0000) begin
      errors++;
      $display("FAIL idle_resolve: perr=%b active=%b, need 1 0000", protocol_err, thread_active);
    end
    tick();
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_pulse: perr=%b, need 0", protocol_err);
    end
    do_start(2'd0, 9'h055);
    tick();
    start_valid = 1;
    start_tid = 2'd0;
    start_pc = 9'h1AA;
    #1;
    checks++;
    if (start_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_start_ready: got %b, need 0", start_ready);
    end
    tick();
    start_valid = 0;
    do_resolve(2'd0, 1'b0, 9'd0, 1'b0);
    wait_issue(ok);
    checks++;
    if (!ok || issue_tid !== 2'd0 || issue_pc !== 9'h056) begin
      errors++;
      $display("FAIL ignored_start: ok=%0d tid=%0d pc=%h, need tid 0 pc 056", ok, issue_tid, issue_pc);
    end
    do_start(2'd1, 9'h100);
    wait_issue(ok);
    checks++;
    if (!ok || issue_tid !== 2'd1 || thread_active !== 4'b0011) begin
      errors++;
      $display("FAIL two_wait: ok=%0d tid=%0d active=%b, need tid 1 active 0011", ok, issue_tid, thread_active);
    end
    apply_reset(1);
    checks++;
    if (thread_active !== 4'b0000 || all_halted !== 1'b1 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: active=%b halted=%b iv=%b, need 0000 1 0", thread_active, all_halted, issue_valid);
    end
    do_resolve(2'd1, 1'b0, 9'd0, 1'b0);
    checks++;
    if (protocol_err !== 1'b1 || thread_active !== 4'b0000) begin
      errors++;
      $display("FAIL late_resolve: perr=%b active=%b, need 1 0000", protocol_err, thread_active);
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset(2);
    for (int c = 0; c < 500; c++) begin
      stall_in = $urandom_range(0, 3) == 0;
      start_valid = $urandom_range(0, 2) == 0;
      start_tid = 2'($urandom_range(0, 3));
      start_pc = 9'($urandom);
      r = $urandom_range(0, 3);
      resolve_valid = (m_fly[r] && $urandom_range(0, 1) == 1) || $urandom_range(0, 19) == 0;
      resolve_tid = 2'(r);
      resolve_taken = 1'($urandom);
      resolve_offset = 9'($urandom);
      resolve_halt = $urandom_range(0, 7) == 0;
      #1;
      checks++;
      if (start_ready !== !m_busy[start_tid]) begin
        errors++;
        $display("FAIL rand_start_ready c%0d: got %b, need %b", c, start_ready, !m_busy[start_tid]);
      end
      tick();
      checks++;
      if (issue_valid !== e_iv || (e_iv && (issue_tid !== 2'(e_tid) || issue_pc !== 9'(e_pc)))) begin
        errors++;
        $display("FAIL rand_issue c%0d: iv=%b tid=%0d pc=%h, need %b %0d %h", c, issue_valid, issue_tid, issue_pc, e_iv, e_tid, e_pc);
      end
      checks++;
      if (thread_active !== m_active() || all_halted !== (m_active() == 4'b0000) || protocol_err !== e_err) begin
        errors++;
        $display("FAIL rand_status c%0d: active=%b halted=%b perr=%b, need %b %b %b",
                 c, thread_active, all_halted, protocol_err, m_active(), m_active() == 4'b0000, e_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_thread();
    test_round_robin();
    test_branch_wrap();
    test_stall_collision();
    test_errors_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
